systolic_drain: RTL and testbench
=================================

Name: systolic_drain

Overview:
- Output-side collector for the systolic array: captures accumulator results leaving the bottom row of PEs.
- Results arrive skewed, one cycle later per column. The block de-skews them into full result rows, buffers the rows in a small FIFO, and presents them on a valid/ready stream to the writeback logic.
- It is the reader of the array's accumulation outputs, as the input skew feeder is their writer.

Parameters:
- COLS, 4, number of array columns (one acc lane per column), >= 2.
- ACC_WIDTH, 32, width of each accumulator result.
- DEPTH, 4, FIFO depth in rows, power of two, >= 2.

Ports:
- clk  input  1  clock.
- rst_n  input  1  asynchronous active-low reset.
- clr  input  1  synchronous flush of the de-skew pipeline, FIFO and overflow flag.
- acc_in  input  COLS*ACC_WIDTH  bottom-row acc_out lanes; column j occupies bits [j*ACC_WIDTH +: ACC_WIDTH].
- row_valid  input  1  high in the cycle column 0 carries a valid result; column j is valid COLS-style j cycles later.
- out_data  output  COLS*ACC_WIDTH  head FIFO row, same lane packing as acc_in.
- out_valid  output  1  FIFO not empty.
- out_ready  input  1  consumer accepts out_data this cycle.
- count  output  $clog2(DEPTH+1)  rows currently in the FIFO.
- overflow  output  1  sticky; set when an aligned row is dropped because the FIFO is full.

Behaviour:
- Reset: one clock, reset asynchronous and active-low. On rst_n low, all delay registers, the FIFO pointers, count, out_valid and overflow go to 0. out_data is 0 while empty.
- De-skew:
  - Column j passes through COLS-1-j register stages. Column COLS-1 is unregistered.
  - row_valid passes through a COLS-1 stage shift register; its output is aligned_valid.
  - When aligned_valid is high, the aligned row is {col COLS-1 current, col COLS-2 delayed 1, ..., col 0 delayed COLS-1}.
  - Delay registers shift every cycle regardless of valid. No stall: the array cannot be back-pressured.
- Back-to-back rows: row_valid may be high on consecutive cycles; each produces one aligned row, COLS-1 cycles later.
- Latency: with the FIFO empty, row_valid at cycle t gives aligned_valid at t+COLS-1, the row written at the end of that cycle, and out_valid=1 at t+COLS. There is no combinational bypass.
- FIFO push: on aligned_valid when count<DEPTH, or when count==DEPTH and a pop occurs in the same cycle.
- FIFO drop: on aligned_valid when count==DEPTH and no pop, the row is dropped and overflow is set (sticky until clr or reset). FIFO contents are unchanged.
- FIFO pop: on out_valid && out_ready. out_data advances to the next row the following cycle.
- out_ready while empty has no effect.
- count: +1 on push only, -1 on pop only, unchanged on simultaneous push+pop. Pointers wrap modulo DEPTH.
- out_data: driven from the head entry (registered storage, combinational read of head). Stable while out_valid && !out_ready.
- clr (synchronous, priority over push/pop in the same cycle): zeroes the valid shift register and delay registers, empties the FIFO, clears overflow. Partially de-skewed rows in flight are discarded.
- Reset mid-operation: all state lost; there is no partial-row recovery.
- No arithmetic is performed on data; lanes are passed bit-exact.

Test Plan (COLS=4, ACC_WIDTH=32, DEPTH=4):
- Single row: row_valid at cycle 0, column j = 0x100+j driven at cycle j, out_ready=1 → out_valid at cycle 4, out_data lanes {0x103,0x102,0x101,0x100}; count returns to 0 at cycle 5.
- Back-to-back: row_valid on cycles 0–3 with row r, column j = 16r+j, out_ready=1 → four consecutive out_valid cycles 4–7 in order r=0..3, each lane correct, overflow=0.
- Backpressure/full: out_ready=0, push 5 rows → count saturates at 4 and overflow=1. Then out_ready=1 → rows 0–3 drain in order; row 4 is never seen.
- Simultaneous push/pop at full: count=4, out_ready=1 in the cycle an aligned row arrives → count stays 4, overflow stays 0, new row appears last.
- clr in flight: row_valid at cycle 0, clr at cycle 2 → out_valid never rises, count=0, previously set overflow cleared.
- Async reset: assert rst_n=0 mid-stream with count=2 → out_valid, count and overflow are 0 immediately, without waiting for a clock edge; a fresh row after release de-skews correctly.

Source files
------------

// File: rtl/systolic_drain_if.sv
// Stream bundle between the systolic array bottom row, the drain collector and writeback.
// The slave view belongs to the collector; master is the environment that drives it.
interface systolic_drain_if #(
  parameter int unsigned COLS      = 4,
  parameter int unsigned ACC_WIDTH = 32,
  parameter int unsigned DEPTH     = 4
);
  logic [COLS*ACC_WIDTH-1:0]     acc_in;
  logic                          row_valid;
  logic [COLS*ACC_WIDTH-1:0]     out_data;
  logic                          out_valid;
  logic                          out_ready;
  logic [$clog2(DEPTH+1)-1:0]    count;
  logic                          overflow;

  modport slave (
    input  acc_in, row_valid, out_ready,
    output out_data, out_valid, count, overflow
  );

  modport master (
    output acc_in, row_valid, out_ready,
    input  out_data, out_valid, count, overflow
  );
endinterface

// File: rtl/systolic_drain.sv
// De-skews accumulator results leaving the bottom PE row into full rows and
// buffers them in a small FIFO presented as a valid/ready stream.
module systolic_drain #(
  parameter int unsigned COLS      = 4,
  parameter int unsigned ACC_WIDTH = 32,
  parameter int unsigned DEPTH     = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  systolic_drain_if.slave  bus
);
  localparam int unsigned W  = COLS * ACC_WIDTH;
  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  logic [COLS-2:0] vld_sr;
  logic            aligned_valid;
  logic [W-1:0]    aligned_row;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_sr <= '0;
    end else if (clr) begin
      vld_sr <= '0;
    end else begin
      vld_sr[0] <= bus.row_valid;
      for (int unsigned i = 1; i < COLS - 1; i++) vld_sr[i] <= vld_sr[i-1];
    end
  end

  assign aligned_valid = vld_sr[COLS-2];

  // Column j needs COLS-1-j stages so that every lane lines up with the last column.
  for (genvar j = 0; j < COLS; j++) begin : g_col
    if (j == COLS - 1) begin : g_pass
      assign aligned_row[j*ACC_WIDTH +: ACC_WIDTH] = bus.acc_in[j*ACC_WIDTH +: ACC_WIDTH];
    end else begin : g_dly
      localparam int unsigned N = COLS - 1 - j;
      logic [ACC_WIDTH-1:0] stage [N];

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          for (int unsigned k = 0; k < N; k++) stage[k] <= '0;
        end else if (clr) begin
          for (int unsigned k = 0; k < N; k++) stage[k] <= '0;
        end else begin
          stage[0] <= bus.acc_in[j*ACC_WIDTH +: ACC_WIDTH];
          for (int unsigned k = 1; k < N; k++) stage[k] <= stage[k-1];
        end
      end

      assign aligned_row[j*ACC_WIDTH +: ACC_WIDTH] = stage[N-1];
    end
  end

  logic [W-1:0]    mem [DEPTH];
  logic [PW-1:0]   wr_ptr;
  logic [PW-1:0]   rd_ptr;
  logic [CW-1:0]   cnt;
  logic            ovf;
  logic            full;
  logic            pop;
  logic            push;
  logic            drop;

  assign full = (cnt == FULL);
  assign pop  = (cnt != '0) && bus.out_ready;
  // A full FIFO still accepts the arriving row when the head leaves in the same cycle.
  assign push = aligned_valid && (!full || pop);
  assign drop = aligned_valid && full && !pop;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
      ovf    <= 1'b0;
    end else if (clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
      ovf    <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)      cnt <= cnt + 1'b1;
      else if (pop && !push) cnt <= cnt - 1'b1;
      if (drop) ovf <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push && !clr) mem[wr_ptr] <= aligned_row;
  end

  assign bus.out_valid = (cnt != '0);
  assign bus.out_data  = (cnt != '0) ? mem[rd_ptr] : '0;
  assign bus.count     = cnt;
  assign bus.overflow  = ovf;
endmodule

// File: tb/tb_systolic_drain.sv
// Scoreboard bench for systolic_drain: a row-level arrival model feeds an expected
// queue, and a negedge monitor compares every presented head row and status output.
module tb_systolic_drain;
  localparam int unsigned COLS      = 4;
  localparam int unsigned ACC_WIDTH = 32;
  localparam int unsigned DEPTH     = 4;
  localparam int unsigned W         = COLS * ACC_WIDTH;

  logic clk;
  logic rst_n;
  logic clr;

  systolic_drain_if #(.COLS(COLS), .ACC_WIDTH(ACC_WIDTH), .DEPTH(DEPTH)) bus ();

  systolic_drain #(.COLS(COLS), .ACC_WIDTH(ACC_WIDTH), .DEPTH(DEPTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (clr),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference state: rows issued keyed by issue cycle, expected FIFO contents and occupancy.
  logic [W-1:0] rows [int];
  logic [W-1:0] exp_q [$];
  int           mcount = 0;
  logic         movf   = 1'b0;
  int           cyc    = 0;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  function automatic logic [W-1:0] rand_row();
    logic [W-1:0] r;
    for (int j = 0; j < COLS; j++) r[j*ACC_WIDTH +: ACC_WIDTH] = ACC_WIDTH'($urandom);
    return r;
  endfunction

  function automatic logic [W-1:0] seq_row(input int base, input int stride);
    logic [W-1:0] r;
    for (int j = 0; j < COLS; j++) r[j*ACC_WIDTH +: ACC_WIDTH] = ACC_WIDTH'(base + stride * j);
    return r;
  endfunction

  // A row issued at cycle t is complete at t+COLS-1 and is then either queued or dropped.
  task automatic model_update();
    int t_arr;
    if (!rst_n) begin
      rows.delete();
      return;
    end
    t_arr = cyc - int'(COLS - 1);
    if (clr) begin
      for (int k = t_arr; k <= cyc; k++) if (rows.exists(k)) rows.delete(k);
      exp_q.delete();
      mcount = 0;
      movf   = 1'b0;
    end else begin
      if (mcount > 0 && bus.out_ready) mcount--;
      if (rows.exists(t_arr)) begin
        if (mcount < int'(DEPTH)) begin
          exp_q.push_back(rows[t_arr]);
          mcount++;
        end else begin
          movf = 1'b1;
        end
        rows.delete(t_arr);
      end
    end
  endtask

  task automatic step(input logic rv, input logic [W-1:0] rdata, input logic rdy, input logic cl);
    logic [W-1:0] lanes;
    logic [W-1:0] src;
    @(posedge clk);
    #1;
    cyc++;
    if (rv) rows[cyc] = rdata;
    lanes = rand_row();
    for (int j = 0; j < COLS; j++) begin
      if (rows.exists(cyc - j)) begin
        src = rows[cyc - j];
        lanes[j*ACC_WIDTH +: ACC_WIDTH] = src[j*ACC_WIDTH +: ACC_WIDTH];
      end
    end
    bus.acc_in    = lanes;
    bus.row_valid = rv;
    bus.out_ready = rdy;
    clr           = cl;
    @(negedge clk);
    #1;
    model_update();
  endtask

  task automatic idle(input int n, input logic rdy);
    for (int i = 0; i < n; i++) step(1'b0, '0, rdy, 1'b0);
  endtask

  always @(negedge clk) begin
    check("count", W'(bus.count), W'(mcount));
    check("overflow", W'(bus.overflow), W'(movf));
    check("out_valid", W'(bus.out_valid), W'(mcount != 0));
    if (bus.out_valid) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL head_row actual=%h required=<no row expected>", bus.out_data);
      end else begin
        check("out_data", bus.out_data, exp_q[0]);
        if (bus.out_ready) void'(exp_q.pop_front());
      end
    end else begin
      check("out_data_empty", bus.out_data, '0);
    end
  end

  initial begin
    rst_n         = 1'b0;
    clr           = 1'b0;
    bus.row_valid = 1'b0;
    bus.out_ready = 1'b0;
    bus.acc_in    = '0;
    #1;
    check("reset_out_valid", W'(bus.out_valid), '0);
    check("reset_count", W'(bus.count), '0);
    check("reset_overflow", W'(bus.overflow), '0);
    @(posedge clk);
    #3;
    rst_n = 1'b1;

    // Single row with lanes 0x100+j.
    step(1'b1, seq_row(32'h100, 1), 1'b1, 1'b0);
    idle(6, 1'b1);

    // Four back-to-back rows, lane j = 16r+j.
    for (int r = 0; r < 4; r++) step(1'b1, seq_row(16 * r, 1), 1'b1, 1'b0);
    idle(6, 1'b1);

    // Backpressure: five rows into a four-deep FIFO, then drain.
    for (int r = 0; r < 5; r++) step(1'b1, rand_row(), 1'b0, 1'b0);
    idle(5, 1'b0);
    idle(6, 1'b1);

    // Flush with a row in flight; also clears the overflow left above.
    step(1'b1, rand_row(), 1'b1, 1'b0);
    idle(1, 1'b1);
    step(1'b0, '0, 1'b1, 1'b1);
    idle(6, 1'b1);

    // Full FIFO with a pop in the exact cycle a fifth row completes.
    for (int r = 0; r < 4; r++) step(1'b1, rand_row(), 1'b0, 1'b0);
    idle(1, 1'b0);
    step(1'b1, rand_row(), 1'b0, 1'b0);
    idle(2, 1'b0);
    idle(1, 1'b1);
    idle(1, 1'b0);
    idle(6, 1'b1);

    // Asynchronous reset with two rows buffered, then a fresh row.
    for (int r = 0; r < 2; r++) step(1'b1, rand_row(), 1'b0, 1'b0);
    idle(4, 1'b0);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("async_out_valid", W'(bus.out_valid), '0);
    check("async_count", W'(bus.count), '0);
    check("async_overflow", W'(bus.overflow), '0);
    exp_q.delete();
    mcount = 0;
    movf   = 1'b0;
    rows.delete();
    idle(2, 1'b0);
    @(posedge clk);
    #3;
    rst_n = 1'b1;
    step(1'b1, seq_row(32'h200, 3), 1'b1, 1'b0);
    idle(6, 1'b1);

    // Randomized traffic: mostly-ready phase, then a heavy-backpressure phase.
    for (int i = 0; i < 300; i++)
      step(1'($urandom_range(0, 1)), rand_row(), 1'($urandom_range(0, 9) < 7),
           1'($urandom_range(0, 59) == 0));
    for (int i = 0; i < 200; i++)
      step(1'($urandom_range(0, 1)), rand_row(), 1'($urandom_range(0, 9) < 3),
           1'($urandom_range(0, 79) == 0));

    idle(DEPTH + COLS + 4, 1'b1);
    check("drained", W'(exp_q.size()), '0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
